// File: rtl/divider.sv
// Iterative radix-2 restoring unsigned divider: 2*SIZE-bit dividend / SIZE-bit divisor.
// Optional rounding sticky bit enabled by defining DIVIDER_STICKY_EN.
module divider #(
    parameter int SIZE = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*SIZE-1:0] dividend,
    input  logic [SIZE-1:0]   divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SIZE-1:0]   quotient,
    output logic [SIZE-1:0]   remainder,
    output logic              overflow,
    output logic              div_by_zero,
    output logic              sticky
);

    localparam int CW = $clog2(SIZE + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q;
    // Partial remainder stays below the divisor, so SIZE bits hold it between iterations.
    logic [SIZE-1:0]   rem_q;
    logic [SIZE-1:0]   sh_q;
    logic [SIZE-1:0]   dvs_q;
    logic [CW-1:0]     cnt_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [SIZE-1:0]   quo_q;
    logic [SIZE-1:0]   rmd_q;
    logic              ovf_q;
    logic              dbz_q;

    logic [SIZE:0]     rshift;
    logic [SIZE:0]     diff;
    logic              ge;
    logic [SIZE-1:0]   rem_d;
    logic [SIZE-1:0]   sh_d;

    // Dividend bits leave the top of sh_q while quotient bits enter at the bottom.
    assign rshift = {rem_q, sh_q[SIZE-1]};
    assign diff   = rshift - {1'b0, dvs_q};
    assign ge     = ~diff[SIZE];
    assign rem_d  = ge ? diff[SIZE-1:0] : rshift[SIZE-1:0];
    assign sh_d   = {sh_q[SIZE-2:0], ge};

`ifdef DIVIDER_STICKY_EN
    logic sticky_q;
    assign sticky = sticky_q;
`else
    assign sticky = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            sh_q        <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quo_q       <= '0;
            rmd_q       <= '0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
`ifdef DIVIDER_STICKY_EN
            sticky_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        dvs_q      <= divisor;
                        in_ready_q <= 1'b0;
                        if (divisor == '0 || dividend[2*SIZE-1:SIZE] >= divisor) begin
                            quo_q       <= '1;
                            rmd_q       <= '0;
                            ovf_q       <= 1'b1;
                            dbz_q       <= (divisor == '0);
`ifdef DIVIDER_STICKY_EN
                            sticky_q    <= 1'b0;
`endif
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            rem_q   <= dividend[2*SIZE-1:SIZE];
                            sh_q    <= dividend[SIZE-1:0];
                            cnt_q   <= CW'(SIZE);
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        quo_q       <= sh_d;
                        rmd_q       <= rem_d;
                        ovf_q       <= 1'b0;
                        dbz_q       <= 1'b0;
`ifdef DIVIDER_STICKY_EN
                        sticky_q    <= (rem_d != '0);
`endif
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;

endmodule
